memory_game_ctrl: RTL and testbench

- Game-logic stage directly upstream of the card renderer in the pepinos memory game.
- Takes the three player buttons and the renderer's start-of-vblank `frame` pulse.
- Maintains the 5x4 grid of 20 cards (10 pairs): cursor position, per-card hidden/revealed/matched state, pair identity, score and move count.
- The renderer reads these outputs to choose each card's colour.

---
 rtl/memory_game_ctrl.sv | 174 +++++++++++++++++
 tb/tb_memory_game_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_game_ctrl.sv
// Game-logic stage for the pepinos memory game: 5x4 card grid,
// cursor, reveal/match FSM, score and move count for the renderer.
module memory_game_ctrl #(
    parameter int COLS            = 5,
    parameter int ROWS            = 4,
    parameter int MISMATCH_FRAMES = 60
) (
    input  logic                       clock_25M,
    input  logic                       reset,
    input  logic                       frame,
    input  logic                       select,
    input  logic                       move_x,
    input  logic                       move_y,
    output logic [2:0]                 cursor_col,
    output logic [1:0]                 cursor_row,
    output logic [2*COLS*ROWS-1:0]     card_state,
    output logic [4*COLS*ROWS-1:0]     card_pair,
    output logic [3:0]                 pairs_found,
    output logic [7:0]                 moves,
    output logic                       game_won
);

    localparam int N  = COLS * ROWS;
    localparam int NP = N / 2;
    localparam int IW = $clog2(N);

    typedef enum logic [2:0] {
        FIRST,
        SECOND,
        COMPARE,
        SHOW_MISMATCH,
        WON
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        sel_sync_q, mx_sync_q, my_sync_q;
    logic [2:0]        col_q, col_d;
    logic [1:0]        row_q, row_d;
    logic [2*N-1:0]    cs_q, cs_d;
    logic [IW-1:0]     a_q, a_d, b_q, b_d;
    logic [3:0]        pairs_q, pairs_d;
    logic [7:0]        moves_q, moves_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              won_q, won_d;

    logic              sel_p, mx_p, my_p;
    logic [IW-1:0]     cur_idx;
    logic              cur_hidden;

    // Rising-edge detect on the second synchroniser stage
    assign sel_p = sel_sync_q[1] & ~sel_sync_q[2];
    assign mx_p  = mx_sync_q[1] & ~mx_sync_q[2];
    assign my_p  = my_sync_q[1] & ~my_sync_q[2];

    assign cur_idx    = IW'(row_q) * IW'(COLS) + IW'(col_q);
    assign cur_hidden = (cs_q[2*cur_idx +: 2] == 2'b00);

    always_comb begin
        card_pair = '0;
        for (int k = 0; k < N; k++) begin
            card_pair[4*k +: 4] = 4'(((k * 3) % N) >> 1);
        end
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cs_d    = cs_q;
        a_d     = a_q;
        b_d     = b_q;
        pairs_d = pairs_q;
        moves_d = moves_q;
        cnt_d   = cnt_q;

        if (state_q != WON) begin
            if (mx_p) col_d = (col_q == 3'(COLS - 1)) ? 3'd0 : col_q + 3'd1;
            if (my_p) row_d = (row_q == 2'(ROWS - 1)) ? 2'd0 : row_q + 2'd1;
        end

        unique case (state_q)
            FIRST: begin
                if (sel_p && cur_hidden) begin
                    cs_d[2*cur_idx +: 2] = 2'b01;
                    a_d     = cur_idx;
                    state_d = SECOND;
                end
            end
            SECOND: begin
                if (sel_p && cur_hidden) begin
                    cs_d[2*cur_idx +: 2] = 2'b01;
                    b_d     = cur_idx;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (moves_q != 8'hFF) moves_d = moves_q + 8'd1;
                if (card_pair[4*a_q +: 4] == card_pair[4*b_q +: 4]) begin
                    cs_d[2*a_q +: 2] = 2'b10;
                    cs_d[2*b_q +: 2] = 2'b10;
                    pairs_d = pairs_q + 4'd1;
                    state_d = (pairs_d == 4'(NP)) ? WON : FIRST;
                end else begin
                    cnt_d   = 8'd0;
                    state_d = SHOW_MISMATCH;
                end
            end
            SHOW_MISMATCH: begin
                if (frame) begin
                    if (cnt_q == 8'(MISMATCH_FRAMES - 1)) begin
                        cs_d[2*a_q +: 2] = 2'b00;
                        cs_d[2*b_q +: 2] = 2'b00;
                        state_d = FIRST;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            WON: begin
                if (sel_p) begin
                    cs_d    = '0;
                    pairs_d = 4'd0;
                    moves_d = 8'd0;
                    col_d   = 3'd0;
                    row_d   = 2'd0;
                    state_d = FIRST;
                end
            end
            default: state_d = FIRST;
        endcase

        won_d = (state_d == WON);
    end

    always_ff @(posedge clock_25M) begin
        if (reset) begin
            state_q    <= FIRST;
            sel_sync_q <= '0;
            mx_sync_q  <= '0;
            my_sync_q  <= '0;
            col_q      <= '0;
            row_q      <= '0;
            cs_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            pairs_q    <= '0;
            moves_q    <= '0;
            cnt_q      <= '0;
            won_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_sync_q <= {sel_sync_q[1:0], select};
            mx_sync_q  <= {mx_sync_q[1:0], move_x};
            my_sync_q  <= {my_sync_q[1:0], move_y};
            col_q      <= col_d;
            row_q      <= row_d;
            cs_q       <= cs_d;
            a_q        <= a_d;
            b_q        <= b_d;
            pairs_q    <= pairs_d;
            moves_q    <= moves_d;
            cnt_q      <= cnt_d;
            won_q      <= won_d;
        end
    end

    assign cursor_col  = col_q;
    assign cursor_row  = row_q;
    assign card_state  = cs_q;
    assign pairs_found = pairs_q;
    assign moves       = moves_q;
    assign game_won    = won_q;

endmodule

// File: tb/tb_memory_game_ctrl.sv
// Directed bench for memory_game_ctrl with an expected-value queue
// checked on the falling edge after each stimulus step.
module tb_memory_game_ctrl;

    logic        clk = 1'b0;
    logic        reset, frame, select, move_x, move_y;
    logic [2:0]  cursor_col;
    logic [1:0]  cursor_row;
    logic [39:0] card_state;
    logic [79:0] card_pair;
    logic [3:0]  pairs_found;
    logic [7:0]  moves;
    logic        game_won;

    memory_game_ctrl dut (
        .clock_25M  (clk),
        .reset      (reset),
        .frame      (frame),
        .select     (select),
        .move_x     (move_x),
        .move_y     (move_y),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .card_state (card_state),
        .card_pair  (card_pair),
        .pairs_found(pairs_found),
        .moves      (moves),
        .game_won   (game_won)
    );

    always #20 clk = ~clk;

    typedef struct {
        string       tag;
        int          sel;
        logic [79:0] exp;
    } sb_t;

    sb_t         sb[$];
    int          checks   = 0;
    int          failures = 0;

    int          m_col, m_row, m_pairs, m_moves;
    logic [39:0] m_cs;
    logic        m_won;
    logic [79:0] exp_deck;

    function automatic int pid(int k);
        return ((k * 3) % 20) / 2;
    endfunction

    function automatic logic [79:0] observe(int s);
        case (s)
            0:       return 80'(cursor_col);
            1:       return 80'(cursor_row);
            2:       return 80'(card_state);
            3:       return 80'(pairs_found);
            4:       return 80'(moves);
            5:       return 80'(game_won);
            default: return card_pair;
        endcase
    endfunction

    function automatic void sb_push(string t, int s, logic [79:0] v);
        sb.push_back('{t, s, v});
    endfunction

    task automatic check_sb();
        sb_t         e;
        logic [79:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.sel);
            checks++;
            assert (obs === e.exp) else begin
                failures++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic check_all(string t);
        sb_push({t, "_col"}, 0, 80'(m_col));
        sb_push({t, "_row"}, 1, 80'(m_row));
        sb_push({t, "_state"}, 2, 80'(m_cs));
        sb_push({t, "_pairs"}, 3, 80'(m_pairs));
        sb_push({t, "_moves"}, 4, 80'(m_moves));
        sb_push({t, "_won"}, 5, 80'(m_won));
        check_sb();
    endtask

    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic btn(bit s, bit x, bit y);
        select = s;
        move_x = x;
        move_y = y;
        tick(1);
        select = 1'b0;
        move_x = 1'b0;
        move_y = 1'b0;
        tick(2);
    endtask

    task automatic step_model(bit x, bit y);
        if (x) m_col = (m_col == 4) ? 0 : m_col + 1;
        if (y) m_row = (m_row == 3) ? 0 : m_row + 1;
    endtask

    task automatic goto_card(int k);
        bit bx, by;
        while (m_col != k % 5 || m_row != k / 5) begin
            bx = (m_col != k % 5);
            by = (m_row != k / 5);
            btn(1'b0, bx, by);
            step_model(bx, by);
        end
    endtask

    task automatic pick(int k);
        goto_card(k);
        btn(1'b1, 1'b0, 1'b0);
        m_cs[2*k +: 2] = 2'b01;
    endtask

    task automatic frames(int n);
        repeat (n) begin
            frame = 1'b1;
            tick(1);
            frame = 1'b0;
            tick(1);
        end
    endtask

    task automatic model_clear();
        m_col   = 0;
        m_row   = 0;
        m_cs    = '0;
        m_pairs = 0;
        m_moves = 0;
        m_won   = 1'b0;
    endtask

    initial begin
        int a, b;
        reset  = 1'b1;
        frame  = 1'b0;
        select = 1'b0;
        move_x = 1'b0;
        move_y = 1'b0;
        model_clear();
        for (int k = 0; k < 20; k++) exp_deck[4*k +: 4] = 4'(pid(k));

        tick(3);
        check_all("reset");
        reset = 1'b0;
        sb_push("deck", 6, exp_deck);
        check_sb();

        move_x = 1'b1;
        tick(10);
        move_x = 1'b0;
        tick(2);
        m_col = 1;
        check_all("hold_x");
        for (int i = 0; i < 4; i++) begin
            btn(1'b0, 1'b1, 1'b0);
            step_model(1'b1, 1'b0);
            check_all("step_x");
        end
        for (int i = 0; i < 4; i++) begin
            btn(1'b0, 1'b0, 1'b1);
            step_model(1'b0, 1'b1);
            check_all("step_y");
        end

        pick(0);
        check_all("pick0");
        pick(7);
        check_all("pick7");
        tick(1);
        m_cs[1:0] = 2'b10;
        m_cs[15:14] = 2'b10;
        m_pairs = 1;
        m_moves = 1;
        check_all("match07");

        pick(2);
        pick(3);
        tick(1);
        m_moves = 2;
        check_all("mism23");
        frames(59);
        check_all("mism59");
        goto_card(4);
        btn(1'b1, 1'b0, 1'b0);
        check_all("mism_sel");
        frames(1);
        m_cs[5:4] = 2'b00;
        m_cs[7:6] = 2'b00;
        check_all("mism60");

        pick(2);
        check_all("sec_a");
        btn(1'b1, 1'b0, 1'b0);
        check_all("sec_again");
        goto_card(0);
        btn(1'b1, 1'b0, 1'b0);
        check_all("sec_matched");
        pick(4);
        tick(1);
        m_moves = 3;
        check_all("sec_b");

        frames(10);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        model_clear();
        check_all("mid_reset");

        for (int p = 0; p < 10; p++) begin
            a = -1;
            b = -1;
            for (int k = 0; k < 20; k++) begin
                if (pid(k) == p) begin
                    if (a < 0) a = k;
                    else b = k;
                end
            end
            pick(a);
            pick(b);
            tick(1);
            m_cs[2*a +: 2] = 2'b10;
            m_cs[2*b +: 2] = 2'b10;
            m_pairs++;
            m_moves++;
            if (m_pairs == 10) m_won = 1'b1;
            check_all("win_pair");
        end
        btn(1'b0, 1'b1, 1'b1);
        check_all("won_move");
        btn(1'b1, 1'b0, 1'b0);
        model_clear();
        check_all("won_sel");

        for (int i = 0; i < 300; i++) begin
            btn(1'b1, 1'b1, 1'b0);
            m_cs[1:0] = 2'b01;
            m_col = 1;
            if (i == 0) check_all("sel_move");
            btn(1'b1, 1'b0, 1'b0);
            m_cs[3:2] = 2'b01;
            tick(1);
            if (m_moves < 255) m_moves++;
            repeat (4) begin
                btn(1'b0, 1'b1, 1'b0);
                step_model(1'b1, 1'b0);
            end
            frames(60);
            m_cs = '0;
            if (i == 0 || i == 253 || i == 254 || i == 299) check_all("sat");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
